// File: rtl/regfile_mp.sv
// Multi-port register file with async clear, write-first bypass, priority write
// collision handling, and a stallable serial dump engine for the debug/trace unit.
module regfile_mp #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*WORD_WIDTH-1:0]   rd_data,
  input  logic [NUM_WRITE-1:0]             wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE*WORD_WIDTH-1:0]  wr_data,
  input  logic                             dump_start,
  input  logic                             dump_stall,
  output logic                             dump_busy,
  output logic                             dump_valid,
  output logic [ADDR_WIDTH-1:0]            dump_idx,
  output logic [WORD_WIDTH-1:0]            dump_data,
  output logic                             dump_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LAST_IDX  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  typedef enum logic {IDLE, DUMP} state_t;

  logic [WORD_WIDTH-1:0] regs [DEPTH];
  logic [NUM_WRITE-1:0]  wr_ok;

  state_t                state_q, state_nx;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_nx;
  logic                  valid_nx, done_nx;
  logic [ADDR_WIDTH-1:0] idx_nx;
  logic [WORD_WIDTH-1:0] data_nx;

  function automatic logic is_zero_addr(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_ZERO);
  endfunction

  // Later ports override earlier ones, so the highest enabled port wins a collision.
  function automatic logic [WORD_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
    logic [WORD_WIDTH-1:0] w;
    w = regs[a];
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_ok[k] && (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == a)) begin
        w = wr_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    if (is_zero_addr(a)) begin
      w = '0;
    end
    return w;
  endfunction

  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      wr_ok[k] = wr_en[k] && !is_zero_addr(wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Storage: NBAs in port order leave the highest-index port's value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_ok[k]) begin
          regs[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[k*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data[i*WORD_WIDTH +: WORD_WIDTH] = read_word(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Dump engine: samples stored contents, i.e. the value before this edge's writes.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    idx_nx   = dump_idx;
    data_nx  = dump_data;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_nx = DUMP;
          cnt_nx   = '0;
        end
      end
      DUMP: begin
        if (!dump_stall) begin
          valid_nx = 1'b1;
          idx_nx   = cnt_q[ADDR_WIDTH-1:0];
          data_nx  = is_zero_addr(cnt_q[ADDR_WIDTH-1:0]) ? '0 : regs[cnt_q[ADDR_WIDTH-1:0]];
          cnt_nx   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      dump_valid <= valid_nx;
      dump_done  <= done_nx;
      dump_idx   <= idx_nx;
      dump_data  <= data_nx;
    end
  end

  // Busy stays up through the final beat so it falls together with valid/done.
  assign dump_busy = (state_q == DUMP) || dump_done;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the single-write, two-read CPU register file.
- Configurable width, depth and read/write port count, with:
  - asynchronous clear;
  - same-cycle write-to-read bypass;
  - deterministic write-port priority;
  - serial dump engine that streams every register out for debug/trace.
- Sits in the decode/writeback stage of the MIPS core; the dump port feeds the debug/trace unit.

Parameters:
- WORD_WIDTH, 32, data bits per register
- ADDR_WIDTH, 5, register address bits; DEPTH = 2**ADDR_WIDTH
- NUM_READ, 2, number of combinational read ports
- NUM_WRITE, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*WORD_WIDTH  packed read data; port i = bits [i*WORD_WIDTH +: WORD_WIDTH]
- wr_en  in  NUM_WRITE  per-port write enable
- wr_addr  in  NUM_WRITE*ADDR_WIDTH  packed write addresses
- wr_data  in  NUM_WRITE*WORD_WIDTH  packed write data
- dump_start  in  1  request a full-register dump; sampled only in IDLE
- dump_stall  in  1  consumer back-pressure; holds the dump sequence
- dump_busy  out  1  high whenever state != IDLE
- dump_valid  out  1  dump_idx/dump_data valid this cycle
- dump_idx  out  ADDR_WIDTH  register index being reported
- dump_data  out  WORD_WIDTH  register contents
- dump_done  out  1  one-cycle pulse, coincident with the last dump_valid

Behaviour:
- Reset (async, rst=1):
  - all DEPTH registers cleared to 0;
  - dump state = IDLE, dump counter = 0;
  - dump_busy / dump_valid / dump_done / dump_idx / dump_data = 0;
  - rd_data reflects cleared contents combinationally.
- Write:
  - on the rising edge, for each port k with wr_en[k]=1, registers[wr_addr[k]] <= wr_data[k].
- Write collision:
  - same address on several enabled ports: highest-index port wins; lower ports are dropped for that address.
- ZERO_REG=1:
  - writes to address 0 are discarded;
  - every read of address 0 returns 0, including bypass and dump.
- Read: combinational, zero latency. For rd_addr[i] = A:
  - if some wr_en[k]=1 with wr_addr[k]=A (and not the ZERO_REG zero case), rd_data[i] = wr_data of the highest such k (write-first bypass);
  - else rd_data[i] = registers[A].
  - Any port may read any address, including duplicates, with no restriction.
- Dump FSM states: IDLE, DUMP.
  - IDLE:
    - on an edge with dump_start=1: go to DUMP, counter = 0, dump_busy = 1.
    - dump_start while busy is ignored (no queueing).
  - DUMP, edge with dump_stall=0:
    - dump_valid <= 1, dump_idx <= counter;
    - dump_data <= stored value of register[counter] before this edge's writes (0 for idx 0 when ZERO_REG);
    - counter++.
  - DUMP, edge with dump_stall=1:
    - dump_valid <= 0, dump_done <= 0;
    - counter holds; no index is skipped.
  - Last register: on the edge emitting counter = DEPTH-1, also dump_done <= 1 and state <= IDLE.
    - dump_busy falls one cycle after that edge, together with dump_valid and dump_done.
  - Latency: with no stalls, the first dump_valid appears one cycle after dump_start is sampled, followed by DEPTH consecutive valid cycles.
  - In IDLE, dump_valid = dump_done = 0; dump_idx/dump_data hold their last values.
- Counter arithmetic:
  - counter is ADDR_WIDTH+1 bits so the termination compare never aliases;
  - dump_idx carries the low ADDR_WIDTH bits.
- Normal reads and writes continue unaffected during a dump.
- Reset mid-dump aborts immediately to IDLE with all outputs 0; no dump_done is issued.

Test Plan:
- Reset then read: assert rst; read addresses 0, 7, 31 on both ports -> all rd_data = 0; dump outputs = 0.
- Write then read: wr_en=01, addr 5, data 0xDEADBEEF -> rd port0 addr 5 returns 0xDEADBEEF in the same cycle (bypass) and in the next cycle (stored).
- Collision: port0 addr 9 data 0x11111111 and port1 addr 9 data 0x22222222, same cycle -> bypass and stored value are both 0x22222222.
- Zero register: write 0xFFFFFFFF to addr 0 with ZERO_REG=1 -> reads and dump idx 0 return 0. With ZERO_REG=0 -> reads return 0xFFFFFFFF.
- Dump with stall:
  - preload reg[i] = i*0x01010101; pulse dump_start; hold dump_stall=1 for 3 cycles at idx 4;
  - -> 32 valid beats, idx 0..31 in order with no gaps or repeats, data matching preload;
  - -> dump_done high only on idx 31; dump_busy low the cycle after.
- Abort: assert rst while dump_idx = 12 -> dump_busy / dump_valid drop immediately and all registers read 0. A new dump_start afterwards restarts at idx 0.
